// File: rtl/adc_capture_sched.sv
// Round-robin capture of NCH sinc3 channels into two ping-pong SRAM banks.
// Define ADC_CAPTURE_TAG_EN to place the 2-bit channel index in mem_data_o[DW-1:DW-2].
module adc_capture_sched #(
    parameter int unsigned NCH = 3,
    parameter int unsigned DW  = 32,
    parameter int unsigned AW  = 9
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [AW:0]       num_words_i,
    input  logic [NCH-1:0]    adc_dvalid_i,
    input  logic [NCH*DW-1:0] adc_dat_i,
    input  logic [1:0]        bank_clr_i,
    output logic [1:0]        mem_wenb_o,
    output logic [AW-1:0]     mem_waddr_o,
    output logic [DW-1:0]     mem_data_o,
    output logic [3:0]        wmask_o,
    output logic [1:0]        bank_ready_o,
    output logic              overflow_o,
    output logic [15:0]       drop_cnt_o,
    output logic              busy_o,
    output logic              irq_o
);
    localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_BANK} state_t;

    state_t         state;
    logic [NCH-1:0] en;
    logic [LW-1:0]  limit;
    logic [DW-1:0]  hold [NCH];
    logic [NCH-1:0] pend;
    logic [CW-1:0]  last;
    logic           bank;
    logic [AW-1:0]  ptr;

    logic           gvalid;
    logic [CW-1:0]  gidx;
    logic [CW-1:0]  cidx;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] drop;
    logic [16:0]    ndrop;
    logic [16:0]    drop_sum;
    logic           last_word;
    logic [1:0]     ready_set;
    int unsigned    k;

    // Round-robin grant, searching from the channel after the last one granted
    always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        cidx   = '0;
        k      = 0;
        gnt    = '0;
        if (state == CAPTURE && !stop_i) begin
            for (int unsigned i = 1; i <= NCH; i++) begin
                k    = (32'(last) + i) % NCH;
                cidx = CW'(k);
                if (!gvalid && pend[cidx]) begin
                    gvalid = 1'b1;
                    gidx   = cidx;
                end
            end
        end
        if (gvalid) gnt[gidx] = 1'b1;
    end

    // Drop detection: a new sample on a still-pending, ungranted channel is lost
    always_comb begin
        drop  = '0;
        ndrop = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            drop[c] = (state != IDLE) && !stop_i && en[c] && adc_dvalid_i[c]
                      && pend[c] && !gnt[c];
            ndrop   = ndrop + 17'(drop[c]);
        end
        drop_sum  = {1'b0, drop_cnt_o} + ndrop;
        last_word = ({1'b0, ptr} == (limit - LW'(1)));
        ready_set = (gvalid && last_word) ? (2'b01 << bank) : 2'b00;
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            en           <= '0;
            limit        <= LW'(DEPTH);
            pend         <= '0;
            last         <= CW'(NCH - 1);
            bank         <= 1'b0;
            ptr          <= '0;
            mem_wenb_o   <= 2'b11;
            mem_waddr_o  <= '0;
            mem_data_o   <= '0;
            wmask_o      <= '0;
            bank_ready_o <= '0;
            overflow_o   <= 1'b0;
            drop_cnt_o   <= '0;
            irq_o        <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) hold[c] <= '0;
        end else begin
            mem_wenb_o   <= 2'b11;
            wmask_o      <= '0;
            irq_o        <= 1'b0;
            bank_ready_o <= (bank_ready_o & ~bank_clr_i) | ready_set;
            case (state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        en         <= ch_en_i;
                        limit      <= (num_words_i == '0 || num_words_i > LW'(DEPTH))
                                      ? LW'(DEPTH) : num_words_i;
                        overflow_o <= 1'b0;
                        drop_cnt_o <= '0;
                        pend       <= '0;
                        ptr        <= '0;
                        bank       <= 1'b0;
                        last       <= CW'(NCH - 1);
                        state      <= bank_ready_o[0] ? WAIT_BANK : CAPTURE;
                    end
                end
                default: begin
                    if (stop_i) begin
                        pend  <= '0;
                        state <= IDLE;
                    end else begin
                        for (int unsigned c = 0; c < NCH; c++) begin
                            if (en[c] && adc_dvalid_i[c] && !drop[c]) begin
                                hold[c] <= adc_dat_i[c*DW +: DW];
                                pend[c] <= 1'b1;
                            end else if (gnt[c]) begin
                                pend[c] <= 1'b0;
                            end
                        end
                        if (|drop) begin
                            overflow_o <= 1'b1;
                            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                        end
                        if (gvalid) begin
                            mem_wenb_o[bank] <= 1'b0;
                            mem_waddr_o      <= ptr;
`ifdef ADC_CAPTURE_TAG_EN
                            mem_data_o       <= {2'(gidx), hold[gidx][DW-3:0]};
`else
                            mem_data_o       <= hold[gidx];
`endif
                            wmask_o          <= 4'hF;
                            last             <= gidx;
                            if (last_word) begin
                                irq_o <= 1'b1;
                                bank  <= ~bank;
                                ptr   <= '0;
                                if (bank_ready_o[~bank]) state <= WAIT_BANK;
                            end else begin
                                ptr <= ptr + AW'(1);
                            end
                        end
                        // Resume once the awaited bank has been drained
                        if (state == WAIT_BANK && !bank_ready_o[bank]) state <= CAPTURE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_sched.sv
// Scoreboard bench for adc_capture_sched: directed stimulus pushes expected writes, a monitor checks them.
module tb_adc_capture_sched;
    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [2:0]  ch_en_i = '0;
    logic [9:0]  num_words_i = '0;
    logic [2:0]  adc_dvalid_i = '0;
    logic [95:0] adc_dat_i = '0;
    logic [1:0]  bank_clr_i = '0;
    logic [1:0]  mem_wenb_o;
    logic [8:0]  mem_waddr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  wmask_o;
    logic [1:0]  bank_ready_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic        busy_o;
    logic        irq_o;

    adc_capture_sched dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i), .stop_i(stop_i),
        .ch_en_i(ch_en_i), .num_words_i(num_words_i), .adc_dvalid_i(adc_dvalid_i),
        .adc_dat_i(adc_dat_i), .bank_clr_i(bank_clr_i), .mem_wenb_o(mem_wenb_o),
        .mem_waddr_o(mem_waddr_o), .mem_data_o(mem_data_o), .wmask_o(wmask_o),
        .bank_ready_o(bank_ready_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .busy_o(busy_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bank;
        logic [8:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  irq_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] td(input int ch, input logic [31:0] d);
`ifdef ADC_CAPTURE_TAG_EN
        return {2'(ch), d[29:0]};
`else
        return d;
`endif
    endfunction

    // Monitor: every write strobe pops one expected write
    always @(negedge clk) begin
        wr_t e;
        if (irq_o) irq_cnt++;
        if (mem_wenb_o != 2'b11) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got wenb=%b addr=%0d data=%h, required no write",
                         mem_wenb_o, mem_waddr_o, mem_data_o);
            end else begin
                e = sb.pop_front();
                chk("wenb", 32'(mem_wenb_o), e.bank ? 32'h1 : 32'h2);
                chk("waddr", 32'(mem_waddr_o), 32'(e.addr));
                chk("wdata", mem_data_o, e.data);
                chk("wmask", 32'(wmask_o), 32'hF);
                if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input logic b, input int a, input logic [31:0] d, input int c);
        wr_t e;
        e.bank = b; e.addr = 9'(a); e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [2:0] dv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
        adc_dvalid_i = dv;
        adc_dat_i    = {d2, d1, d0};
        @(posedge clk); #1;
        adc_dvalid_i = '0;
    endtask

    task automatic start(input logic [2:0] en, input int n);
        ch_en_i = en; num_words_i = 10'(n); start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic stop();
        stop_i = 1'b1;
        @(posedge clk); #1;
        stop_i = 1'b0;
    endtask

    task automatic clr(input logic [1:0] m);
        bank_clr_i = m;
        @(posedge clk); #1;
        bank_clr_i = '0;
    endtask

    initial begin
        idle(3);
        wb_rst_i = 1'b0;
        chk("rst_wenb", 32'(mem_wenb_o), 32'h3);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(bank_ready_o), 32'h0);
        chk("rst_status", {14'h0, overflow_o, irq_o, drop_cnt_o}, 32'h0);
        chk("rst_addr_data", mem_data_o | 32'(mem_waddr_o) | 32'(wmask_o), 32'h0);

        // Single channel, N=4: fills bank0, then switches to bank1
        start(3'b001, 4);
        chk("busy_after_start", 32'(busy_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            push(1'b0, i, td(0, 32'h11 + 32'(i)), cyc + 2);
            issue(3'b001, 32'h11 + 32'(i), 32'h0, 32'h0);
            idle(2);
        end
        idle(1);
        chk("t1_ready", 32'(bank_ready_o), 32'h1);
        chk("t1_irq", 32'(irq_cnt), 32'h1);
        push(1'b1, 0, td(0, 32'h15), cyc + 2);
        issue(3'b001, 32'h15, 32'h0, 32'h0);
        idle(3);
        stop();
        chk("t1_idle", 32'(busy_o), 32'h0);
        chk("t1_partial_not_flagged", 32'(bank_ready_o), 32'h1);
        clr(2'b01);
        chk("t1_cleared", 32'(bank_ready_o), 32'h0);

        // All channels at once, twice: order ch0,ch1,ch2 each time (N=0 clamps to 512)
        start(3'b111, 0);
        push(1'b0, 0, td(0, 32'hA0), cyc + 2);
        push(1'b0, 1, td(1, 32'hA1), cyc + 3);
        push(1'b0, 2, td(2, 32'hAB), cyc + 4);
        issue(3'b111, 32'hA0, 32'hA1, 32'hAB);
        idle(4);
        push(1'b0, 3, td(0, 32'hB0), cyc + 2);
        push(1'b0, 4, td(1, 32'hB1), cyc + 3);
        push(1'b0, 5, td(2, 32'hB2), cyc + 4);
        issue(3'b111, 32'hB0, 32'hB1, 32'hB2);
        idle(4);

        // Second ch1 sample while all pending is dropped; first ch1 value is written
        push(1'b0, 6, td(0, 32'hC0), cyc + 2);
        push(1'b0, 7, td(1, 32'hC1), cyc + 3);
        push(1'b0, 8, td(2, 32'hC2), cyc + 4);
        issue(3'b111, 32'hC0, 32'hC1, 32'hC2);
        issue(3'b010, 32'h0, 32'hC9, 32'h0);
        idle(4);
        chk("t3_drop_cnt", 32'(drop_cnt_o), 32'h1);
        chk("t3_overflow", 32'(overflow_o), 32'h1);
        chk("t3_no_bank_done", 32'(bank_ready_o), 32'h0);
        stop();

        // N=2 with no clears: both banks fill, then WAIT_BANK
        start(3'b001, 2);
        chk("t4_start_clears_drop", {15'h0, overflow_o, drop_cnt_o}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            push(1'b0 ^ (i >= 2), i % 2, td(0, 32'hD1 + 32'(i)), cyc + 2);
            issue(3'b001, 32'hD1 + 32'(i), 32'h0, 32'h0);
            idle(2);
        end
        issue(3'b001, 32'hD5, 32'h0, 32'h0);
        idle(2);
        issue(3'b001, 32'hD6, 32'h0, 32'h0);
        idle(3);
        chk("t4_both_ready", 32'(bank_ready_o), 32'h3);
        chk("t4_drop_cnt", 32'(drop_cnt_o), 32'h1);
        chk("t4_busy_waiting", 32'(busy_o), 32'h1);
        chk("t4_irq", 32'(irq_cnt), 32'h3);
        push(1'b0, 0, td(0, 32'hD5), -1);
        clr(2'b01);
        idle(4);
        chk("t4_resumed", 32'(sb.size()), 32'h0);
        chk("t4_ready_after", 32'(bank_ready_o), 32'h2);

        // Clear of bank0 on the same edge it completes: the set wins
        push(1'b0, 1, td(0, 32'hD7), cyc + 2);
        issue(3'b001, 32'hD7, 32'h0, 32'h0);
        clr(2'b01);
        idle(1);
        chk("t5_set_wins", 32'(bank_ready_o), 32'h3);
        chk("t5_irq", 32'(irq_cnt), 32'h4);
        stop();
        clr(2'b11);

        // Reset in the middle of a write
        start(3'b100, 4);
        push(1'b0, 0, td(2, 32'hE1), cyc + 2);
        issue(3'b100, 32'h0, 32'h0, 32'hE1);
        @(posedge clk); #1;
        chk("t6_wenb_active", 32'(mem_wenb_o), 32'h2);
        wb_rst_i = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_wenb", 32'(mem_wenb_o), 32'h3);
        chk("t6_rst_busy", 32'(busy_o), 32'h0);
        chk("t6_rst_data", mem_data_o | 32'(mem_waddr_o) | 32'(wmask_o), 32'h0);
        chk("t6_rst_status", {13'h0, bank_ready_o, irq_o, drop_cnt_o}, 32'h0);
        wb_rst_i = 1'b0;
        idle(3);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
